// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - core fetch/data ports and shared SRAM port bundle
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_rd_i;
  logic [31:0]       i_rdata_o;
  logic              i_valid_o;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [1:0]        d_size_i;
  logic              d_rd_i;
  logic              d_wr_i;
  logic [31:0]       d_rdata_o;
  logic              d_valid_o;
  logic              stall_o;
  logic              err_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic              m_en_o;
  logic              m_we_o;
  logic [3:0]        m_be_o;
  logic [31:0]       m_wdata_o;
  logic [31:0]       m_rdata_i;

  // arbiter side
  modport slave (
    input  i_addr_i, i_rd_i, d_addr_i, d_wdata_i, d_size_i, d_rd_i, d_wr_i, m_rdata_i,
    output i_rdata_o, i_valid_o, d_rdata_o, d_valid_o, stall_o, err_o,
           m_addr_o, m_en_o, m_we_o, m_be_o, m_wdata_o
  );

  // core + memory side
  modport master (
    output i_addr_i, i_rd_i, d_addr_i, d_wdata_i, d_size_i, d_rd_i, d_wr_i, m_rdata_i,
    input  i_rdata_o, i_valid_o, d_rdata_o, d_valid_o, stall_o, err_o,
           m_addr_o, m_en_o, m_we_o, m_be_o, m_wdata_o
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin fetch/data arbiter for one single-port SRAM (optional RISCV_ARB_MISALIGN_EN)
module riscv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  riscv_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t      state_q, state_d;
  logic        last_d_q;          // 1 = data port received the most recent grant
  logic        grant_i, grant_d;
  logic        i_elig, d_elig, d_req;
  logic        i_valid, d_valid;
  logic        misalign;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [1:0]  lane_q, size_q;
  logic        load_q, err_q;
  logic [31:0] d_load_data;
  logic [31:0] i_hold_q, d_hold_q;
  logic        unused_bits;

  assign d_req       = bus.d_rd_i | bus.d_wr_i;
  assign i_valid     = (state_q == IBUSY);
  assign d_valid     = (state_q == DBUSY);
  assign unused_bits = ^bus.i_addr_i[1:0];

`ifdef RISCV_ARB_MISALIGN_EN
  assign misalign = (bus.d_size_i == 2'd1) ? bus.d_addr_i[0]
                                           : (bus.d_size_i[1] && (bus.d_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // lane, byte enables and replicated store data from the access size
  always_comb begin
    lane      = 2'b00;
    be        = 4'b1111;
    wdata_rep = bus.d_wdata_i;
    case (bus.d_size_i)
      2'd0: begin
        lane      = bus.d_addr_i[1:0];
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.d_wdata_i[7:0]}};
      end
      2'd1: begin
        lane      = {bus.d_addr_i[1], 1'b0};
        be        = 4'b0011 << lane;
        wdata_rep = {2{bus.d_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // retire-then-grant: the retiring port sits out, ties go to the port not granted last
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = IDLE;
    i_elig  = reset_i & bus.i_rd_i & ~i_valid;
    d_elig  = reset_i & d_req & ~d_valid;
    if (i_elig && d_elig) begin
      if (last_d_q) grant_i = 1'b1;
      else          grant_d = 1'b1;
    end else if (i_elig) begin
      grant_i = 1'b1;
    end else if (d_elig) begin
      grant_d = 1'b1;
    end
    if (grant_i)      state_d = IBUSY;
    else if (grant_d) state_d = DBUSY;
  end

  // memory strobe for the access granted this cycle; misaligned grants never touch memory
  always_comb begin
    bus.m_addr_o  = '0;
    bus.m_en_o    = 1'b0;
    bus.m_we_o    = 1'b0;
    bus.m_be_o    = 4'b0000;
    bus.m_wdata_o = '0;
    if (grant_i) begin
      bus.m_addr_o = {bus.i_addr_i[ADDR_W-1:2], 2'b00};
      bus.m_en_o   = 1'b1;
      bus.m_be_o   = 4'b1111;
    end else if (grant_d && !misalign) begin
      bus.m_addr_o  = {bus.d_addr_i[ADDR_W-1:2], 2'b00};
      bus.m_en_o    = 1'b1;
      bus.m_we_o    = bus.d_wr_i;
      bus.m_be_o    = be;
      bus.m_wdata_o = bus.d_wr_i ? wdata_rep : 32'h0;
    end
  end

  // state, round-robin history and the context of the data access in flight
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      last_d_q <= ~DATA_FIRST;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i)      last_d_q <= 1'b0;
      else if (grant_d) last_d_q <= 1'b1;
      if (grant_d) begin
        lane_q <= lane;
        size_q <= bus.d_size_i;
        load_q <= ~bus.d_wr_i;
        err_q  <= misalign;
      end
    end
  end

  // align the SRAM word to the right and zero everything above the access size
  always_comb begin
    d_load_data = bus.m_rdata_i >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    d_load_data = d_load_data & 32'h0000_00FF;
      2'd1:    d_load_data = d_load_data & 32'h0000_FFFF;
      default: ;
    endcase
    if (err_q) d_load_data = 32'h0;
  end

  // keep the last delivered data visible between completion pulses
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      i_hold_q <= 32'h0;
      d_hold_q <= 32'h0;
    end else begin
      if (i_valid) i_hold_q <= bus.m_rdata_i;
      if (d_valid && (load_q || err_q)) d_hold_q <= d_load_data;
    end
  end

  assign bus.i_valid_o = i_valid;
  assign bus.d_valid_o = d_valid;
  assign bus.err_o     = d_valid & err_q;
  assign bus.i_rdata_o = i_valid ? bus.m_rdata_i : i_hold_q;
  assign bus.d_rdata_o = (d_valid && (load_q || err_q)) ? d_load_data : d_hold_q;
  assign bus.stall_o   = reset_i & ((bus.i_rd_i & ~i_valid) | (d_req & ~d_valid));

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and data port. It grants one access per cycle with round-robin priority and stalls the core via `stall_o` while a request waits. On writes it generates byte enables and lane-replicated write data from the access size. On reads it returns the lane-aligned read data. It sits between `riscv_core_sim`-class cores and the shared memory model.

## Interface
Parameters:
- `ADDR_W`, 32, address width of core and memory ports.
- `DATA_FIRST`, 1, initial tie-break after reset: 1 = data wins the first simultaneous request, 0 = instruction wins.

Ports (reset `reset_i`, asynchronous, active-low; clock `clk_i`):
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous active-low reset.
- `i_addr_i` in ADDR_W: fetch address (word aligned).
- `i_rd_i` in 1: fetch request.
- `i_rdata_o` out 32: fetched instruction.
- `i_valid_o` out 1: fetch complete, one-cycle pulse.
- `d_addr_i` in ADDR_W: data address.
- `d_wdata_i` in 32: store data, right-justified.
- `d_size_i` in 2: access size; 0 = byte, 1 = half, 2 = word.
- `d_rd_i` in 1: load request.
- `d_wr_i` in 1: store request.
- `d_rdata_o` out 32: load data, right-justified and zero-filled above the access size.
- `d_valid_o` out 1: data access complete, one-cycle pulse.
- `stall_o` out 1: a request is pending and not completing this cycle.
- `err_o` out 1: misaligned data access. Pulses with `d_valid_o`.
- `m_addr_o` out ADDR_W: memory word address, with bits [1:0] = 0.
- `m_en_o` out 1: memory access strobe.
- `m_we_o` out 1: memory write.
- `m_be_o` out 4: byte enables.
- `m_wdata_o` out 32: memory write data.
- `m_rdata_i` in 32: memory read data, valid one cycle after an `m_en_o` read.

## Operation
- FSM states:
  - IDLE: nothing outstanding.
  - IBUSY: fetch issued last cycle.
  - DBUSY: data access issued last cycle.
- Every cycle:
  - Retire the outstanding access, if any.
  - Then grant at most one new access.
  - The next state is set by the new grant: IDLE if none, IBUSY for a fetch, DBUSY for a data access.
- Eligibility: a port is eligible when its request is high and the port is not retiring this cycle. A port never receives back-to-back grants.
- Both ports eligible: grant the port not granted last. The last-grant flop resets to instruction when `DATA_FIRST`=1.
- `d_rd_i` and `d_wr_i` both high: treated as a store.
- Requesters hold address, size, data and request stable until their `*_valid_o` pulse. They may drop the request in the cycle after the pulse.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - Size 3: treated as word.
- Write data:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata` unchanged.
- Load data:
  - `m_rdata_i` is shifted right by `8*lane`. Lane is `addr[1:0]` for byte, `{addr[1],0}` for half, 0 for word.
  - The result is masked to the access size.
  - Sign extension is not done here; the core owns it.
- `stall_o` = `(i_rd_i & ~i_valid_o) | ((d_rd_i|d_wr_i) & ~d_valid_o)`. This is combinational from the registered valids.

## Timing
- Latency: grant in cycle N (`m_en_o`=1), then `*_valid_o` and data in cycle N+1.
- Single requester: one access every 2 cycles. Both requesters: one access per cycle, alternating.
- `m_*` outputs are combinational from the grant decision. `i_rdata_o`, `d_rdata_o`, `*_valid_o` and `err_o` are registered.
- Rdata outputs hold their last value between pulses.
- Reset values: all outputs 0, state IDLE.
- Reset asserted while an access is outstanding: the access is dropped and no valid pulse follows. A store already strobed to memory is not undone.

## Configuration
- With `RISCV_ARB_MISALIGN_EN` defined, an access is misaligned if it is a half with `addr[0]`=1, or a word with `addr[1:0]`≠0. A misaligned data access:
  - is granted, but `m_en_o` stays 0;
  - pulses `d_valid_o` and `err_o` in N+1;
  - returns `d_rdata_o`=0.
- Without `RISCV_ARB_MISALIGN_EN`:
  - `err_o` is tied to 0;
  - misaligned accesses proceed using the lane rules above, so low address bits beyond the size alignment are ignored.

## Test plan
- Fetch-only, `i_addr_i`=0x10 held, memory word 0x00500093 → `m_en_o` in cycle 1, `i_valid_o`=1 with `i_rdata_o`=0x00500093 in cycle 2, `stall_o`=1 only in cycle 1.
- Simultaneous fetch and load after reset with `DATA_FIRST`=1 → data granted first, fetch next cycle, `d_valid_o` and `i_valid_o` in consecutive cycles, alternating while both are held.
- Store byte 0xAB at addr 0x103 → `m_be_o`=4'b1000, `m_wdata_o`=0xABABABAB, `m_addr_o`=0x100. Load half from 0x102 over word 0xDEADBEEF → `d_rdata_o`=0x0000DEAD.
- With `RISCV_ARB_MISALIGN_EN`, word load at 0x106 → no `m_en_o`, `d_valid_o`=`err_o`=1 one cycle later, `d_rdata_o`=0. Without the macro, the same load reads word 0x104 and `err_o`=0.
- `reset_i` low in the cycle after a fetch grant → no `i_valid_o` pulse, all outputs 0, and the first grant after release follows the `DATA_FIRST` tie-break.
